// File: rtl/abl_pkg.sv
// Shared definitions for the 8-bit ALU datapath: default widths and ALU opcode
// encodings, so that control, ALU, register file and benches all agree.
package abl_pkg;

  localparam int ABL_DATA_W   = 8;
  localparam int ABL_ADDR_W   = 2;
  localparam int ABL_NUM_REGS = 4;
  localparam int ABL_CNT_W    = 8;

  typedef enum logic [2:0] {
    ALU_NOP  = 3'b000,
    ALU_ADD  = 3'b001,
    ALU_SUB  = 3'b010,
    ALU_NAND = 3'b011,
    ALU_SHL  = 3'b100,
    ALU_SHR  = 3'b101
  } aluop_t;

endpackage

// File: rtl/reg_file_flags_if.sv
// Bus between control/ALU and the operand register file: read/write ports,
// ALU flag inputs and the registered flag / write-count outputs.
interface reg_file_flags_if
  import abl_pkg::*;
#(
  parameter int DATA_W = ABL_DATA_W,
  parameter int ADDR_W = ABL_ADDR_W
);

  logic [ADDR_W-1:0]    readSel1;
  logic [ADDR_W-1:0]    readSel2;
  logic [ADDR_W-1:0]    writeSel;
  logic [DATA_W-1:0]    writeData;
  logic                 regWrite;
  logic                 aluZero;
  logic                 aluNeg;
  logic                 flagWrite;
  logic [DATA_W-1:0]    readReg1;
  logic [DATA_W-1:0]    readReg2;
  logic                 flagZero;
  logic                 flagNeg;
  logic [ABL_CNT_W-1:0] writeCount;

  modport master (
    output readSel1, readSel2, writeSel, writeData, regWrite,
           aluZero, aluNeg, flagWrite,
    input  readReg1, readReg2, flagZero, flagNeg, writeCount
  );

  modport slave (
    input  readSel1, readSel2, writeSel, writeData, regWrite,
           aluZero, aluNeg, flagWrite,
    output readReg1, readReg2, flagZero, flagNeg, writeCount
  );

endinterface

// File: rtl/reg_file_flags_flag_reg.sv
// Two-bit ZERO/NEG status register; both bits load together when enabled and
// clear on synchronous active-high reset.
module flag_reg
  import abl_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic zero_in,
  input  logic neg_in,
  output logic zero_o,
  output logic neg_o
);

  logic zero_d, zero_q;
  logic neg_d,  neg_q;

  always_comb begin
    zero_d = zero_q;
    neg_d  = neg_q;
    if (en) begin
      zero_d = zero_in;
      neg_d  = neg_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
    end else begin
      zero_q <= zero_d;
      neg_q  <= neg_d;
    end
  end

  assign zero_o = zero_q;
  assign neg_o  = neg_q;

endmodule

// File: rtl/reg_file_flags.sv
// Operand register file (2 read, 1 write) plus ALU status flags and a write counter.
// Optional macro REGFILE_WRITE_BYPASS_EN forwards writeData to a read port selecting writeSel.
module reg_file_flags
  import abl_pkg::*;
#(
  parameter int DATA_W   = ABL_DATA_W,
  parameter int NUM_REGS = ABL_NUM_REGS,
  parameter int ADDR_W   = ABL_ADDR_W
) (
  input  logic             clk,
  input  logic             reset,
  reg_file_flags_if.slave  rf
);

  logic [DATA_W-1:0]    regs_d [NUM_REGS];
  logic [DATA_W-1:0]    regs_q [NUM_REGS];
  logic [ABL_CNT_W-1:0] write_count_d, write_count_q;

  logic rd1_in_range, rd2_in_range, wr_in_range;

  // Out-of-range selects only exist when NUM_REGS is not a power of two.
  assign rd1_in_range = (int'(rf.readSel1) < NUM_REGS);
  assign rd2_in_range = (int'(rf.readSel2) < NUM_REGS);
  assign wr_in_range  = (int'(rf.writeSel) < NUM_REGS);

  always_comb begin
    regs_d        = regs_q;
    write_count_d = write_count_q;
    if (rf.regWrite && wr_in_range) begin
      regs_d[rf.writeSel] = rf.writeData;
      write_count_d       = write_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q        <= '{default: '0};
      write_count_q <= '0;
    end else begin
      regs_q        <= regs_d;
      write_count_q <= write_count_d;
    end
  end

  always_comb begin
    rf.readReg1 = rd1_in_range ? regs_q[rf.readSel1] : '0;
    rf.readReg2 = rd2_in_range ? regs_q[rf.readSel2] : '0;
`ifdef REGFILE_WRITE_BYPASS_EN
    if (!reset && rf.regWrite && wr_in_range) begin
      if (rf.readSel1 == rf.writeSel) rf.readReg1 = rf.writeData;
      if (rf.readSel2 == rf.writeSel) rf.readReg2 = rf.writeData;
    end
`endif
  end

  assign rf.writeCount = write_count_q;

  flag_reg u_flag_reg (
    .clk     (clk),
    .reset   (reset),
    .en      (rf.flagWrite),
    .zero_in (rf.aluZero),
    .neg_in  (rf.aluNeg),
    .zero_o  (rf.flagZero),
    .neg_o   (rf.flagNeg)
  );

endmodule

// File: tb/tb_reg_file_flags.sv
// Directed self-checking bench for reg_file_flags: reset, write/read, read-during-write,
// flags, same-index dual read and write-counter wrap.
module tb_reg_file_flags;
  import abl_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   vec = 0;
  int   err = 0;

  reg_file_flags_if #(.DATA_W(8), .ADDR_W(2)) rf ();

  reg_file_flags #(.DATA_W(8), .NUM_REGS(4), .ADDR_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .rf    (rf.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rf.regWrite  = 1'b0;
    rf.flagWrite = 1'b0;
  endtask

  task automatic do_write(input logic [1:0] sel, input logic [7:0] data);
    rf.regWrite  = 1'b1;
    rf.writeSel  = sel;
    rf.writeData = data;
    tick();
    rf.regWrite  = 1'b0;
  endtask

  task automatic test_reset();
    // State straight out of the power-on reset
    for (int i = 0; i < 4; i++) begin
      rf.readSel1 = 2'(i);
      #1;
      vec++;
      if (rf.readReg1 !== 8'h00) begin
        err++; $display("FAIL por_reg%0d got %h want 00", i, rf.readReg1);
      end
    end
    vec++;
    if (rf.writeCount !== 8'd0 || rf.flagZero !== 1'b0 || rf.flagNeg !== 1'b0) begin
      err++; $display("FAIL por_ctrl got cnt=%0d z=%b n=%b want 0 0 0",
                      rf.writeCount, rf.flagZero, rf.flagNeg);
    end
    // Load r1 and both flags, then reset with a write pending
    rf.aluZero = 1'b1; rf.aluNeg = 1'b1; rf.flagWrite = 1'b1;
    do_write(2'd1, 8'h55);
    rf.flagWrite = 1'b0;
    rf.readSel1 = 2'd1;
    #1;
    vec++;
    if (rf.readReg1 !== 8'h55 || rf.writeCount !== 8'd1 || rf.flagZero !== 1'b1 || rf.flagNeg !== 1'b1) begin
      err++; $display("FAIL pre_reset got r1=%h cnt=%0d z=%b n=%b want 55 1 1 1",
                      rf.readReg1, rf.writeCount, rf.flagZero, rf.flagNeg);
    end
    reset = 1'b1;
    rf.flagWrite = 1'b1;
    do_write(2'd1, 8'hAA);
    reset = 1'b0;
    idle();
    for (int i = 0; i < 4; i++) begin
      rf.readSel2 = 2'(i);
      #1;
      vec++;
      if (rf.readReg2 !== 8'h00) begin
        err++; $display("FAIL reset_reg%0d got %h want 00", i, rf.readReg2);
      end
    end
    vec++;
    if (rf.writeCount !== 8'd0 || rf.flagZero !== 1'b0 || rf.flagNeg !== 1'b0) begin
      err++; $display("FAIL reset_ctrl got cnt=%0d z=%b n=%b want 0 0 0",
                      rf.writeCount, rf.flagZero, rf.flagNeg);
    end
  endtask

  task automatic test_basic_write();
    do_write(2'd2, 8'h7F);
    do_write(2'd3, 8'h80);
    rf.readSel1 = 2'd2;
    rf.readSel2 = 2'd3;
    rf.writeData = 8'hEE;
    #1;
    vec++;
    if (rf.readReg1 !== 8'h7F) begin
      err++; $display("FAIL basic_r2 got %h want 7f", rf.readReg1);
    end
    vec++;
    if (rf.readReg2 !== 8'h80) begin
      err++; $display("FAIL basic_r3 got %h want 80", rf.readReg2);
    end
    vec++;
    if (rf.writeCount !== 8'd2) begin
      err++; $display("FAIL basic_cnt got %0d want 2", rf.writeCount);
    end
  endtask

  task automatic test_read_during_write();
    logic [7:0] exp_same;
`ifdef REGFILE_WRITE_BYPASS_EN
    exp_same = 8'h22;
`else
    exp_same = 8'h11;
`endif
    do_write(2'd1, 8'h11);
    rf.readSel1  = 2'd1;
    rf.readSel2  = 2'd2;
    rf.regWrite  = 1'b1;
    rf.writeSel  = 2'd1;
    rf.writeData = 8'h22;
    #1;
    vec++;
    if (rf.readReg1 !== exp_same) begin
      err++; $display("FAIL rdw_same got %h want %h", rf.readReg1, exp_same);
    end
    vec++;
    if (rf.readReg2 !== 8'h7F) begin
      err++; $display("FAIL rdw_other got %h want 7f", rf.readReg2);
    end
    tick();
    idle();
    #1;
    vec++;
    if (rf.readReg1 !== 8'h22 || rf.writeCount !== 8'd4) begin
      err++; $display("FAIL rdw_next got r1=%h cnt=%0d want 22 4", rf.readReg1, rf.writeCount);
    end
  endtask

  task automatic test_flags();
    rf.aluZero = 1'b1; rf.aluNeg = 1'b0; rf.flagWrite = 1'b1;
    tick();
    rf.flagWrite = 1'b0;
    vec++;
    if (rf.flagZero !== 1'b1 || rf.flagNeg !== 1'b0) begin
      err++; $display("FAIL flag_load got z=%b n=%b want 1 0", rf.flagZero, rf.flagNeg);
    end
    rf.aluZero = 1'b0; rf.aluNeg = 1'b1;
    tick();
    vec++;
    if (rf.flagZero !== 1'b1 || rf.flagNeg !== 1'b0) begin
      err++; $display("FAIL flag_hold got z=%b n=%b want 1 0", rf.flagZero, rf.flagNeg);
    end
    // Both enables in one cycle
    rf.flagWrite = 1'b1;
    do_write(2'd0, 8'h01);
    rf.flagWrite = 1'b0;
    vec++;
    if (rf.flagZero !== 1'b0 || rf.flagNeg !== 1'b1 || rf.writeCount !== 8'd5) begin
      err++; $display("FAIL flag_with_write got z=%b n=%b cnt=%0d want 0 1 5",
                      rf.flagZero, rf.flagNeg, rf.writeCount);
    end
  endtask

  task automatic test_dual_port();
    do_write(2'd0, 8'hC3);
    rf.readSel1 = 2'd0;
    rf.readSel2 = 2'd0;
    #1;
    vec++;
    if (rf.readReg1 !== 8'hC3 || rf.readReg2 !== 8'hC3) begin
      err++; $display("FAIL dual_same got %h %h want c3 c3", rf.readReg1, rf.readReg2);
    end
  endtask

  task automatic test_counter_wrap();
    // Count is 6 here; 250 more writes land exactly on 256 -> 0
    for (int i = 0; i < 250; i++) begin
      do_write(2'(i), 8'(i));
      if (i == 248) begin
        vec++;
        if (rf.writeCount !== 8'd255) begin
          err++; $display("FAIL wrap_255 got %0d want 255", rf.writeCount);
        end
      end
    end
    vec++;
    if (rf.writeCount !== 8'd0) begin
      err++; $display("FAIL wrap_zero got %0d want 0", rf.writeCount);
    end
    rf.readSel1 = 2'd0;
    rf.readSel2 = 2'd2;
    #1;
    vec++;
    if (rf.readReg1 !== 8'hF8 || rf.readReg2 !== 8'hF6) begin
      err++; $display("FAIL wrap_data got %h %h want f8 f6", rf.readReg1, rf.readReg2);
    end
    rf.writeSel = 2'd0;
    rf.writeData = 8'h99;
    tick();
    vec++;
    if (rf.writeCount !== 8'd0 || rf.readReg1 !== 8'hF8) begin
      err++; $display("FAIL hold_no_write got cnt=%0d r0=%h want 0 f8", rf.writeCount, rf.readReg1);
    end
    do_write(2'd3, 8'h3C);
    vec++;
    if (rf.writeCount !== 8'd1) begin
      err++; $display("FAIL post_wrap_inc got %0d want 1", rf.writeCount);
    end
  endtask

  initial begin
    reset = 1'b1;
    rf.readSel1 = '0; rf.readSel2 = '0; rf.writeSel = '0; rf.writeData = '0;
    rf.regWrite = 1'b0; rf.aluZero = 1'b0; rf.aluNeg = 1'b0; rf.flagWrite = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    test_reset();
    test_basic_write();
    test_read_during_write();
    test_flags();
    test_dual_port();
    test_counter_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule

// File: doc/reg_file_flags.md
Name: reg_file_flags

Overview:
- Operand register file plus status-flag register sitting directly upstream of the 8-bit ALU.
- Two read ports drive the ALU operand inputs readReg1/readReg2.
- One write port is fed back from the ALU result.
- A flag register latches the ALU ZERO/NEG outputs for later branch decisions by the control unit.

Parameters:
- DATA_W, 8, register and data width in bits.
- NUM_REGS, 4, number of general registers.
- ADDR_W, 2, select width; must equal clog2(NUM_REGS).

Ports:
- clk  input  1  system clock (post clock-divider); all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- readSel1  input  ADDR_W  register index for read port 1.
- readSel2  input  ADDR_W  register index for read port 2.
- writeSel  input  ADDR_W  register index for the write port.
- writeData  input  DATA_W  data to write (ALU result or immediate, muxed by control).
- regWrite  input  1  write enable for the register array.
- aluZero  input  1  ZERO flag from ALU.
- aluNeg  input  1  NEG flag from ALU.
- flagWrite  input  1  enable to latch aluZero/aluNeg into the flag register.
- readReg1  output  DATA_W  contents of register readSel1 (to ALU).
- readReg2  output  DATA_W  contents of register readSel2 (to ALU).
- flagZero  output  1  registered ZERO flag.
- flagNeg  output  1  registered NEG flag.
- writeCount  output  8  count of committed register writes; wraps at 255 -> 0.

Behaviour:
- Reset (synchronous): on a rising clk with reset=1, all NUM_REGS registers, flagZero, flagNeg and writeCount clear to 0. Reset overrides regWrite and flagWrite in the same cycle; no write commits.
- Reads: combinational from the array; readReg1/readReg2 change within the same cycle as readSel1/readSel2. Both ports may select the same register.
- Write: when reset=0 and regWrite=1 at the rising edge, reg[writeSel] <= writeData and writeCount <= writeCount+1 (8-bit modulo wrap, 255 -> 0). With regWrite=0, the array and writeCount hold.
- Read-during-write, without the optional feature: a read of writeSel in the write cycle returns the OLD value; the new value is visible from the next cycle.
- Flags: when reset=0 and flagWrite=1 at the edge, flagZero <= aluZero and flagNeg <= aluNeg, both updated together. Otherwise both hold. Flags are independent of regWrite; both enables may be asserted in the same cycle.
- Writes to all indices 0..NUM_REGS-1 are legal; no hardwired-zero register.
- Out-of-range selects (only possible if NUM_REGS < 2^ADDR_W): reads return 0; writes are dropped and writeCount does not increment.
- Signedness: data is stored raw; the register file does no arithmetic or sign handling.
- Reset mid-operation: a pending write in the reset cycle is discarded; the first write is accepted in the cycle after reset deasserts.

Optional Feature:
- Macro: REGFILE_WRITE_BYPASS_EN.
- Defined: when regWrite=1 and readSelN == writeSel (in range, reset=0), readRegN returns writeData combinationally in that same cycle (write-through forwarding).
- Undefined: reads return the stored value only, as described above.
- Storage and writeCount behaviour are identical in both builds.

Decomposition:
- Shared package `abl_pkg`: DATA_W and ADDR_W defaults; ALUOP encodings (NOP=000, ADD=001, SUB=010, NAND=011, SHL=100, SHR=101) so control, ALU and benches agree.
- Sub-module `flag_reg`: 2-bit enable register for ZERO/NEG with synchronous reset. Everything else stays flat.

Test Plan:
- Reset: write 8'h55 to r1, assert reset with regWrite=1 and writeData=8'hAA -> all registers read 0, writeCount=0, flags=0 on the following cycle.
- Basic write/read: write r2=8'h7F, then r3=8'h80; set readSel1=2, readSel2=3 -> readReg1=8'h7F, readReg2=8'h80, writeCount=2.
- Read-during-write: r1 holds 8'h11; write r1=8'h22 with readSel1=1 -> readReg1=8'h11 that cycle (8'h22 with REGFILE_WRITE_BYPASS_EN); 8'h22 next cycle in both builds.
- Flags: aluZero=1, aluNeg=0, flagWrite=1 -> flagZero=1, flagNeg=0; then aluNeg=1 with flagWrite=0 -> flags unchanged.
- Counter wrap: 256 consecutive writes -> writeCount returns to 0; a cycle with regWrite=0 -> no increment.
- Dual-port same index: readSel1=readSel2=0 after writing r0=8'hC3 -> both ports read 8'hC3.
